// File: rtl/tinyarch_pkg.sv
// Purpose: shared types and constants for the tinyarch fetch/decode pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: jump_mode_e (decoder next-PC request), fetch_state_e (fetch FSM),
//           HALT_INSTR (unary op 7, the program terminator seen by both sides).
package tinyarch_pkg;

    typedef enum logic [1:0] {
        JM_STEP    = 2'd0,
        JM_SKIP_NZ = 2'd1,
        JM_SKIP    = 2'd2,
        JM_JUMP    = 2'd3
    } jump_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

    localparam logic [8:0] HALT_INSTR = 9'h1FF;

endpackage

// File: rtl/instr_fetch_unit_pc_next.sv
// Purpose: next-PC selection from the decoder's jump request.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
// Ports: pc (current PC), jump_mode (0 step, 1 skip-if-nonzero, 2 skip, 3 jump),
//        cond_nonzero, jmp_hi/jmp_lo (jump target bytes) -> pc_nxt.
module pc_next
    import tinyarch_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0] pc,
    input  logic [1:0]      jump_mode,
    input  logic            cond_nonzero,
    input  logic [7:0]      jmp_hi,
    input  logic [7:0]      jmp_lo,
    output logic [PC_W-1:0] pc_nxt
);

    logic [15:0] jmp_target;

    assign jmp_target = {jmp_hi, jmp_lo};

    // All arithmetic is PC_W wide, so wrap modulo 2**PC_W comes for free.
    always_comb begin
        pc_nxt = pc + PC_W'(1);
        case (jump_mode_e'(jump_mode))
            JM_STEP:    pc_nxt = pc + PC_W'(1);
            JM_SKIP_NZ: pc_nxt = cond_nonzero ? pc + PC_W'(2) : pc + PC_W'(1);
            JM_SKIP:    pc_nxt = pc + PC_W'(2);
            JM_JUMP:    pc_nxt = PC_W'(jmp_target);  // upper target bits dropped
            default:    pc_nxt = pc + PC_W'(1);
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose: owns the PC, reads the instruction ROM and presents one instruction per slot.
// Latency: 2 cycles per instruction (FETCH then EXEC); first instr_valid 2 cycles after start.
// Backpressure: none; the decoder must consume every EXEC slot, start only honoured in IDLE/DONE.
// Ports: clk/rst_n; start/done handshake; finished to decoder; imem_addr/imem_data to the
//        1-cycle synchronous ROM; instr/instr_valid to decoder; jump_mode, cond_nonzero,
//        jmp_hi/jmp_lo from decoder; pc and retired_cnt status.
module instr_fetch_unit #(
    parameter int                 PC_W       = 10,
    parameter int                 INSTR_W    = 9,
    parameter logic [PC_W-1:0]    START_ADDR = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = tinyarch_pkg::HALT_INSTR,
    parameter int                 CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               done,
    output logic               finished,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic [1:0]         jump_mode,
    input  logic               cond_nonzero,
    input  logic [7:0]         jmp_hi,
    input  logic [7:0]         jmp_lo,
    output logic [PC_W-1:0]    pc,
    output logic [CNT_W-1:0]   retired_cnt
);

    import tinyarch_pkg::*;

    fetch_state_e    state;
    logic [PC_W-1:0] pc_nxt;
    logic            is_halt;

    // ROM address tracks pc directly; the read issued in FETCH lands in EXEC.
    assign imem_addr   = pc;
    assign instr       = imem_data;
    assign instr_valid = (state == EXEC);
    assign is_halt     = (instr == HALT_INSTR);
    assign done        = (state == DONE);
    // Raised already in the halting EXEC slot so the decoder can block its memory write.
    assign finished    = (state == DONE) || ((state == EXEC) && is_halt);

    pc_next #(
        .PC_W(PC_W)
    ) u_pc_next (
        .pc           (pc),
        .jump_mode    (jump_mode),
        .cond_nonzero (cond_nonzero),
        .jmp_hi       (jmp_hi),
        .jmp_lo       (jmp_lo),
        .pc_nxt       (pc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= START_ADDR;
            retired_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pc          <= START_ADDR;
                        retired_cnt <= '0;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    state <= EXEC;
                end
                EXEC: begin
                    if (retired_cnt != {CNT_W{1'b1}}) begin
                        retired_cnt <= retired_cnt + CNT_W'(1);
                    end
                    // Halt wins over any jump request; pc stays on the halt word.
                    if (is_halt) begin
                        state <= DONE;
                    end else begin
                        pc    <= pc_nxt;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose: self-checking bench for instr_fetch_unit with a ROM and decoder stand-in.
// Latency: n/a.
// Backpressure: n/a.
module tb_instr_fetch_unit;

    localparam logic [8:0] HALT = 9'h1FF;
    localparam int         NPC  = 1024;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        done;
    logic        finished;
    logic [9:0]  imem_addr;
    logic [8:0]  imem_data;
    logic [8:0]  instr;
    logic        instr_valid;
    logic [1:0]  jump_mode;
    logic        cond_nonzero;
    logic [7:0]  jmp_hi;
    logic [7:0]  jmp_lo;
    logic [9:0]  pc;
    logic [15:0] retired_cnt;

    // Program image plus the decoder's per-address next-PC request.
    logic [8:0]  rom  [NPC];
    logic [1:0]  jm_t [NPC];
    logic        cz_t [NPC];
    logic [15:0] tg_t [NPC];

    int n_pass = 0;
    int n_fail = 0;
    int n_chk  = 0;
    int mpc    = 0;
    int mret   = 0;
    bit halted;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .done         (done),
        .finished     (finished),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .jump_mode    (jump_mode),
        .cond_nonzero (cond_nonzero),
        .jmp_hi       (jmp_hi),
        .jmp_lo       (jmp_lo),
        .pc           (pc),
        .retired_cnt  (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clk) imem_data <= rom[imem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int a = 0; a < NPC; a++) begin
            rom[a]  = 9'($urandom_range(510, 0));
            jm_t[a] = 2'd0;
            cz_t[a] = 1'b0;
            tg_t[a] = 16'h0000;
        end
    endtask

    task automatic random_prog();
        for (int a = 0; a < NPC; a++) begin
            rom[a]  = ($urandom_range(15, 0) == 0) ? HALT : 9'($urandom_range(510, 0));
            jm_t[a] = 2'($urandom_range(3, 0));
            cz_t[a] = 1'($urandom_range(1, 0));
            tg_t[a] = 16'($urandom);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mpc   = 0;
        mret  = 0;
        chk("start_fetch_valid", instr_valid, 0);
        chk("start_pc", pc, 0);
        chk("start_cnt", retired_cnt, 0);
        chk("start_done", done, 0);
    endtask

    // Steps the model one slot at a time; start is toggled randomly in FETCH/EXEC
    // because it must be ignored there.
    task automatic run(input int budget, input bit hold_start, output bit hlt);
        int nxt;
        hlt = 1'b0;
        for (int s = 0; s < budget && !hlt; s++) begin
            jump_mode          = jm_t[mpc];
            cond_nonzero       = cz_t[mpc];
            {jmp_hi, jmp_lo}   = tg_t[mpc];
            start              = 1'($urandom_range(1, 0));
            @(negedge clk);
            chk("exec_valid", instr_valid, 1);
            chk("exec_instr", instr, rom[mpc]);
            chk("exec_pc", pc, mpc);
            chk("exec_cnt", retired_cnt, mret);
            chk("exec_finished", finished, (rom[mpc] == HALT) ? 1 : 0);
            mret = (mret == 65535) ? mret : mret + 1;
            if (rom[mpc] == HALT) begin
                hlt   = 1'b1;
                start = hold_start;
                @(negedge clk);
                chk("done_done", done, 1);
                chk("done_finished", finished, 1);
                chk("done_valid", instr_valid, 0);
                chk("done_pc", pc, mpc);
                chk("done_cnt", retired_cnt, mret);
            end else begin
                case (jm_t[mpc])
                    2'd0:    nxt = mpc + 1;
                    2'd1:    nxt = mpc + (cz_t[mpc] ? 2 : 1);
                    2'd2:    nxt = mpc + 2;
                    default: nxt = int'(tg_t[mpc]);
                endcase
                mpc   = nxt % NPC;
                start = 1'($urandom_range(1, 0));
                @(negedge clk);
                chk("fetch_valid", instr_valid, 0);
                chk("fetch_pc", pc, mpc);
                chk("fetch_addr", imem_addr, mpc);
                chk("fetch_cnt", retired_cnt, mret);
                chk("fetch_done", done, 0);
            end
        end
        if (!hlt) start = 1'b0;
    endtask

    // Asynchronous reset asserted in the middle of a low clock phase.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_finished"}, finished, 0);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_cnt"}, retired_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_idle_valid"}, instr_valid, 0);
        chk({tag, "_idle_pc"}, pc, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        jump_mode    = 2'd0;
        cond_nonzero = 1'b0;
        jmp_hi       = 8'h00;
        jmp_lo       = 8'h00;
        clear_prog();
        repeat (2) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_finished", finished, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_cnt", retired_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_valid", instr_valid, 0);

        // Straight line: three movi then HALT.
        rom[0] = 9'h041;
        rom[1] = 9'h042;
        rom[2] = 9'h043;
        rom[3] = HALT;
        do_start();
        run(10, 1'b0, halted);
        chk("line_halted", halted, 1);
        chk("line_retired", retired_cnt, 4);

        // Unconditional skip from 0 lands on 2.
        clear_prog();
        jm_t[0] = 2'd2;
        rom[2]  = HALT;
        do_start();
        run(10, 1'b0, halted);
        chk("skip_halted", halted, 1);
        chk("skip_pc", pc, 2);

        // Conditional skip at pc 5, both condition values.
        clear_prog();
        jm_t[0] = 2'd3;
        tg_t[0] = 16'h0005;
        jm_t[5] = 2'd1;
        cz_t[5] = 1'b0;
        rom[6]  = HALT;
        rom[7]  = HALT;
        do_start();
        run(10, 1'b0, halted);
        chk("cskip0_pc", pc, 6);
        cz_t[5] = 1'b1;
        do_start();
        run(10, 1'b0, halted);
        chk("cskip1_pc", pc, 7);

        // Jump with discarded high bits, wrap on skip, halt beats a jump request,
        // then start held high through DONE.
        clear_prog();
        jm_t[0]      = 2'd3;
        tg_t[0]      = 16'hFE34;
        jm_t[10'h234] = 2'd3;
        tg_t[10'h234] = 16'h03FF;
        jm_t[10'h3FF] = 2'd2;
        rom[1]       = HALT;
        jm_t[1]      = 2'd3;
        tg_t[1]      = 16'h0055;
        do_start();
        run(10, 1'b1, halted);
        chk("jump_halted", halted, 1);
        chk("jump_halt_pc", pc, 1);
        @(negedge clk);
        start = 1'b0;
        mpc   = 0;
        mret  = 0;
        chk("rerun_done", done, 0);
        chk("rerun_valid", instr_valid, 0);
        chk("rerun_pc", pc, 0);
        chk("rerun_cnt", retired_cnt, 0);
        run(10, 1'b0, halted);
        chk("rerun_halted", halted, 1);
        chk("rerun_retired", retired_cnt, 4);

        // Jump to own address loops forever; reset lands in the middle of EXEC.
        clear_prog();
        jm_t[0]   = 2'd3;
        tg_t[0]   = 16'h0100;
        jm_t[256] = 2'd3;
        tg_t[256] = 16'h0100;
        do_start();
        run(5, 1'b0, halted);
        chk("loop_no_halt", halted, 0);
        chk("loop_pc", pc, 10'h100);
        @(negedge clk);
        chk("loop_exec_valid", instr_valid, 1);
        do_reset("exec_rst");

        // Random programs against the model, each ended by an async reset.
        for (int r = 0; r < 4; r++) begin
            random_prog();
            do_start();
            run(40, 1'b0, halted);
            do_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
